// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a polled STATUS register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq_empty
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
    localparam logic PARITY_FLAG = 1'b1;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
    localparam logic PARITY_FLAG = 1'b0;
`endif

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, count_next_s;
    logic              overflow_r, overflow_next_s;
    state_t            state_r, state_next_s;
    logic [BAUD_W-1:0] baud_r, baud_next_s;
    logic [2:0]        bit_cnt_r, bit_cnt_next_s;
    logic [7:0]        shift_r, shift_next_s;
    logic              parity_r, parity_next_s;
    logic              tx_r, tx_next_s;
    logic              irq_r, irq_next_s;

    logic wr_sel_s, push_req_s, clr_ovf_s, full_s, empty_s, push_s, pop_s, baud_end_s;
    logic unused_s;

    assign unused_s   = ^{wdata[31:8], addr[1:0]};
    assign wr_sel_s   = sel && we;
    assign push_req_s = wr_sel_s && (addr[3:2] == 2'd0);
    assign clr_ovf_s  = wr_sel_s && (addr[3:2] == 2'd1) && wdata[3];
    assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    // Full is judged before any same-cycle pop, so a write into a full FIFO is always dropped.
    assign push_s     = push_req_s && !full_s;
    assign baud_end_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state, shifter and serial-output decode.
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        parity_next_s  = parity_r;
        pop_s          = 1'b0;
        baud_next_s    = baud_end_s ? {BAUD_W{1'b0}} : baud_r + BAUD_W'(1);
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s          = 1'b1;
                    shift_next_s   = mem_r[rd_ptr_r];
                    parity_next_s  = even_parity(mem_r[rd_ptr_r]);
                    bit_cnt_next_s = 3'd0;
                    state_next_s   = ST_START;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end_s && !empty_s) begin
                    pop_s          = 1'b1;
                    shift_next_s   = mem_r[rd_ptr_r];
                    parity_next_s  = even_parity(mem_r[rd_ptr_r]);
                    bit_cnt_next_s = 3'd0;
                    state_next_s   = ST_START;
                end else if (baud_end_s) begin
                    state_next_s   = ST_IDLE;
                end else begin
                    state_next_s   = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (state_next_s != state_r || state_r == ST_IDLE) begin
            baud_next_s = {BAUD_W{1'b0}};
        end else begin
            baud_next_s = baud_next_s;
        end

        // tx is registered, so it is decoded from the state being entered.
        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next_s = parity_next_s;
`endif
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // FIFO occupancy, overflow flag and interrupt decode.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        if (push_req_s && full_s) begin
            overflow_next_s = 1'b1;
        end else if (clr_ovf_s) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
        irq_next_s = (count_next_s == {CNT_W{1'b0}}) && (state_next_s == ST_IDLE);
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata[7:0];
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            state_r    <= ST_IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            irq_r      <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            overflow_r <= overflow_next_s;
            state_r    <= state_next_s;
            baud_r     <= baud_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            parity_r   <= parity_next_s;
            tx_r       <= tx_next_s;
            irq_r      <= irq_next_s;
        end
    end

    // Combinational load path for the single-cycle core.
    always_comb begin
        rdata = 32'h0000_0000;
        if (sel) begin
            case (addr[3:2])
                2'd1:    rdata = {27'd0, PARITY_FLAG, overflow_r, (state_r != ST_IDLE), empty_s, full_s};
                default: rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign tx        = tx_r;
    assign irq_empty = irq_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized self-checking bench for mmio_uart_tx; expected tx waveforms are built
// from the frame format and compared cycle by cycle.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam logic [31:0] ST_IDLE_VAL = 32'h2 | (PAR << 4);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq_empty;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int stream_start = 0;
    bit stream_armed = 1'b0;
    bit exp_q[$];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .tx(tx), .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level for one frame: start, 8 data LSB first, optional even parity, stop.
    function automatic void push_frame(input logic [7:0] b);
        for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < CPB; i++) exp_q.push_back(b[k]);
        if (PAR != 0)
            for (int i = 0; i < CPB; i++) exp_q.push_back(^b);
        for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (!stream_armed && a[3:2] == 2'd0) begin
            stream_start = cyc;
            stream_armed = 1'b1;
        end
        sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0; addr = 4'h0;
    endtask

    // Compares tx against exp_q from the cycle after the first data write onward.
    task automatic check_stream(input string name);
        int guard = 0;
        int idx = 0;
        bit e;
        do begin @(negedge clk); guard++; end while (!stream_armed && guard < 2000);
        do begin
            if (cyc != stream_start + 1) @(negedge clk);
            guard++;
        end while (cyc != stream_start + 1 && guard < 4000);
        tests_run++;
        if (cyc != stream_start + 1) begin
            tests_failed++;
            $display("FAIL %s start: cycle %0d, required %0d", name, cyc, stream_start + 1);
            exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (tx !== e) begin
                tests_failed++;
                $display("FAIL %s bit %0d: tx=%b, required %b", name, idx, tx, e);
            end
            idx++;
            @(negedge clk);
        end
        stream_armed = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(4'h4, d);
        tests_run++;
        if (d !== exp) begin
            tests_failed++;
            $display("FAIL %s status: got 0x%0h, required 0x%0h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset tx: got %b, required 1", tx); end
        tests_run++;
        if (irq_empty !== 1'b1) begin tests_failed++; $display("FAIL reset irq_empty: got %b, required 1", irq_empty); end
        check_status("reset", ST_IDLE_VAL);
    endtask

    task automatic test_single();
        logic [7:0] bytes[2];
        bytes[0] = 8'h55;
        bytes[1] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 2; n++) begin
            bus_write(4'h0, {24'h0, bytes[n]});
            push_frame(bytes[n]);
            push_idle(6);
            check_stream("single");
            check_status("single_after", ST_IDLE_VAL);
            tests_run++;
            if (irq_empty !== 1'b1) begin tests_failed++; $display("FAIL single irq_empty: got %b, required 1", irq_empty); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        for (int n = 0; n < 2; n++) begin
            a = (n == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
            b = (n == 0) ? 8'h0F : 8'($urandom_range(0, 255));
            push_frame(a);
            push_frame(b);
            push_idle(6);
            fork
                begin bus_write(4'h0, {24'h0, a}); bus_write(4'h0, {24'h0, b}); end
                check_stream("back_to_back");
            join
            check_status("b2b_after", ST_IDLE_VAL);
        end
    endtask

    // A burst from idle: the first byte moves to the shifter, DEPTH more fit, the rest are dropped.
    task automatic run_burst(input string name, input logic [7:0] bytes[$]);
        int accepted;
        accepted = (bytes.size() > DEPTH + 1) ? DEPTH + 1 : bytes.size();
        for (int i = 0; i < accepted; i++) push_frame(bytes[i]);
        push_idle(8);
        fork
            begin
                foreach (bytes[i]) bus_write(4'h0, {24'h0, bytes[i]});
            end
            check_stream(name);
        join
        check_status(name, ST_IDLE_VAL | ((bytes.size() > DEPTH + 1) ? 32'h8 : 32'h0));
        bus_write(4'h4, 32'h8);
        check_status({name, "_clr"}, ST_IDLE_VAL);
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        for (int i = 1; i <= 6; i++) q.push_back(8'(i));
        run_burst("overflow", q);
        q.delete();
        for (int i = 1; i <= 6; i++) q.push_back(8'(i));
        for (int i = 0; i < 6; i++) push_frame(8'h00);
        exp_q.delete();
        fork
            foreach (q[i]) bus_write(4'h0, {24'h0, q[i]});
        join
        stream_armed = 1'b0;
        bus_write(4'h4, 32'h0000_0017);
        check_status("ovf_no_clear", 32'hD | (PAR << 4));
        bus_write(4'h4, 32'h8);
        check_status("ovf_clear_busy", 32'h5 | (PAR << 4));
        repeat (6 * 10 * CPB) @(negedge clk);
        check_status("ovf_drain", ST_IDLE_VAL);
    endtask

    task automatic test_random_burst();
        logic [7:0] q[$];
        for (int r = 0; r < 3; r++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(1, 7); i++) q.push_back(8'($urandom_range(0, 255)));
            run_burst("rand_burst", q);
        end
    endtask

    task automatic test_regmap();
        logic [31:0] d;
        int lows = 0;
        bus_write(4'h8, 32'h41);
        bus_write(4'hC, 32'h42);
        foreach (d[i]) ;
        for (int a = 0; a < 4; a++) begin
            if (a != 1) begin
                bus_read(4'(a * 4), d);
                tests_run++;
                if (d !== 32'h0) begin tests_failed++; $display("FAIL regmap read off %0d: got 0x%0h, required 0", a * 4, d); end
            end
        end
        @(negedge clk);
        sel = 1'b0; addr = 4'h4;
        #1;
        tests_run++;
        if (rdata !== 32'h0) begin tests_failed++; $display("FAIL regmap unselected: got 0x%0h, required 0", rdata); end
        addr = 4'h0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        tests_run++;
        if (lows != 0) begin tests_failed++; $display("FAIL regmap ignored write: %0d low cycles, required 0", lows); end
        check_status("regmap", ST_IDLE_VAL);
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        int lows = 0;
        bus_write(4'h0, 32'hFF);
        bus_write(4'h0, {24'h0, 8'($urandom_range(0, 255))});
        do begin @(negedge clk); guard++; end while (cyc != stream_start + 15 && guard < 100);
        stream_armed = 1'b0;
        tests_run++;
        if (tx !== 1'b1 || irq_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe pre: tx=%b irq=%b, required tx=1 irq=0", tx, irq_empty);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL midframe tx: got %b, required 1", tx); end
        tests_run++;
        if (irq_empty !== 1'b1) begin tests_failed++; $display("FAIL midframe irq_empty: got %b, required 1", irq_empty); end
        check_status("midframe", ST_IDLE_VAL);
        for (int i = 0; i < 3 * 10 * CPB; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        tests_run++;
        if (lows != 0) begin tests_failed++; $display("FAIL midframe no_frame: %0d low cycles, required 0", lows); end
    endtask

    task automatic test_parity();
        logic [31:0] d;
        bus_write(4'h0, 32'h07);
        push_frame(8'h07);
        push_idle(4);
        check_stream("parity_frame");
        bus_read(4'h4, d);
        tests_run++;
        if (d[4] !== 1'(PAR)) begin tests_failed++; $display("FAIL parity status bit4: got %b, required %0d", d[4], PAR); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_random_burst();
        test_regmap();
        test_reset_midframe();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
